// File: rtl/sobel_stream_pkg.sv
// Shared types and the combinational Sobel datapath for sobel_stream.
// Contents:
//   state_t    - frame FSM states
//   MODE_*     - output mode encodings for mode_i
//   window_t   - 3x3 pixel window, [row][col], row 0 = oldest row, col 0 = leftmost
//   sobel_mag  - |Gx| + |Gy| of a window (unsigned, MAG_W bits)
// Window pixels are stored zero-extended to WIN_PIX_W bits, so any PIX_W up to
// WIN_PIX_W shares the same function and the arithmetic result is unchanged.
package sobel_stream_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_LAST   = 2'd2
    } state_t;

    localparam logic MODE_MAG = 1'b0;
    localparam logic MODE_THR = 1'b1;

    localparam int WIN_PIX_W = 16;
    localparam int MAG_W     = WIN_PIX_W + 4;

    typedef logic [2:0][2:0][WIN_PIX_W-1:0] window_t;

    function automatic logic [MAG_W-1:0] sobel_mag(input window_t w);
        logic signed [MAG_W-1:0] p [3][3];
        logic signed [MAG_W-1:0] gx;
        logic signed [MAG_W-1:0] gy;
        logic signed [MAG_W-1:0] ax;
        logic signed [MAG_W-1:0] ay;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                p[r][c] = signed'({4'b0000, w[r][c]});
            end
        end
        // Doubling is written as a self-add to keep every term at MAG_W bits.
        gx = (p[0][2] + p[1][2] + p[1][2] + p[2][2])
           - (p[0][0] + p[1][0] + p[1][0] + p[2][0]);
        gy = (p[2][0] + p[2][1] + p[2][1] + p[2][2])
           - (p[0][0] + p[0][1] + p[0][1] + p[0][2]);
        ax = gx[MAG_W-1] ? -gx : gx;
        ay = gy[MAG_W-1] ? -gy : gy;
        return unsigned'(ax + ay);
    endfunction

endpackage

// File: rtl/sobel_stream_line_buffer.sv
// One image row of storage for sobel_stream.
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   addr_i   - shared read/write address (column)
//   wdata_i  - write data
//   rdata_o  - asynchronous read data at addr_i (old contents during a write)
module sobel_line_buffer #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_stream.sv
// Streaming Sobel edge filter with two internal line buffers.
// Consumes a raster-order pixel stream and emits the (IMG_W-2)x(IMG_H-2)
// interior results, saturated magnitude (mode 0) or binary threshold (mode 1).
// Ports:
//   clk_i, rst_i                       - clock, synchronous active-high reset
//   mode_i, thresh_i                   - output mode / threshold, latched on first pixel
//   in_valid_i, in_ready_o, in_data_i  - input pixel handshake
//   out_valid_o, out_ready_i,
//   out_data_o, out_last_o             - result handshake, last marks final result
//   busy_o                             - frame in progress
//   frame_done_o                       - pulse when final result is accepted
module sobel_stream
    import sobel_stream_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int PIX_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mode_i,
    input  logic [PIX_W+3:0] thresh_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [PIX_W-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PIX_W-1:0] out_data_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_t                       state_q, state_d;
    logic [COL_W-1:0]             col_q, col_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic                         mode_q;
    logic [PIX_W+3:0]             thresh_q;
    // Right two columns of the last window; they become cols 0/1 of the next one.
    logic [2:0][1:0][WIN_PIX_W-1:0] cols_q;
    window_t                      win_d;
    logic                         out_valid_q, out_valid_d;
    logic [PIX_W-1:0]             out_data_q, out_data_d;
    logic                         out_last_q, out_last_d;
    logic [PIX_W-1:0]             lb0_rd, lb1_rd;
    logic [MAG_W-1:0]             mag;
    logic                         accept, produce, last_pix, drain;

    function automatic logic [PIX_W-1:0] sat_pix(input logic [MAG_W-1:0] m);
        logic [MAG_W-1:0] lim;
        lim = MAG_W'({PIX_W{1'b1}});
        return (m > lim) ? {PIX_W{1'b1}} : m[PIX_W-1:0];
    endfunction

    function automatic logic [PIX_W-1:0] thr_pix(input logic [MAG_W-1:0] m,
                                                 input logic [PIX_W+3:0] t);
        return (m >= MAG_W'(t)) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
    endfunction

    assign in_ready_o   = (state_q != S_LAST) && (!out_valid_q || out_ready_i);
    assign accept       = in_valid_i && in_ready_o;
    assign drain        = out_valid_q && out_ready_i;
    assign last_pix     = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign produce      = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_last_o   = out_last_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = (state_q == S_LAST) && drain;

    // lb0 holds the previous row; lb1 takes lb0's old value (row before that).
    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk_i   (clk_i),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (in_data_i),
        .rdata_o (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk_i   (clk_i),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = cols_q[r][0];
            win_d[r][1] = cols_q[r][1];
        end
        win_d[0][2] = WIN_PIX_W'(lb1_rd);
        win_d[1][2] = WIN_PIX_W'(lb0_rd);
        win_d[2][2] = WIN_PIX_W'(in_data_i);
    end

    assign mag = sobel_mag(win_d);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_STREAM;
            S_STREAM: if (accept && last_pix) state_d = S_LAST;
            S_LAST:   if (drain) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // A new result may load in the same cycle the old one drains.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (drain) begin
            out_valid_d = 1'b0;
        end
        if (produce) begin
            out_valid_d = 1'b1;
            out_data_d  = (mode_q == MODE_THR) ? thr_pix(mag, thresh_q) : sat_pix(mag);
            out_last_d  = last_pix;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                cols_q[r][0] <= win_d[r][1];
                cols_q[r][1] <= win_d[r][2];
            end
        end
        if (accept && (state_q == S_IDLE)) begin
            mode_q   <= mode_i;
            thresh_q <= thresh_i;
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
module tb_sobel_stream;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int PW   = 8;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst_i;
    logic          mode_i;
    logic [PW+3:0] thresh_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [PW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [PW-1:0] out_data_o;
    logic          out_last_o;
    logic          busy_o;
    logic          frame_done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int img [H][W];
    int exp_q [$];

    typedef struct {
        int lo;
        int hi;
        int mode;
        int thr;
        int chg_thr;
        int rdy;
        int exp [6];
    } vec_t;

    vec_t vt [5];

    always #5 clk = ~clk;

    sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .mode_i       (mode_i),
        .thresh_i     (thresh_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference Sobel over the whole image, interior pixels in raster order.
    task automatic fill_model(input int mode, input int thr);
        exp_q.delete();
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                int gx, gy, mag;
                gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
                   - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
                gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
                   - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
                mag = absi(gx) + absi(gy);
                if (mode == 0) exp_q.push_back((mag > 255) ? 255 : mag);
                else           exp_q.push_back((mag >= thr) ? 255 : 0);
            end
        end
    endtask

    task automatic fill_step(input int lo, input int hi);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (c < 4) ? lo : hi;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_out_data", int'(out_data_o), 0);
        chk("rst_out_last", int'(out_last_o), 0);
        chk("rst_frame_done", int'(frame_done_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_in_ready", int'(in_ready_o), 1);
    endtask

    // Streams img through the DUT; checks each accepted output against exp_q
    // unless abort_at > 0, in which case it stops quietly after that many accepts.
    task automatic run_frame(input string tag, input int mode, input int thr,
                             input int chg_thr, input int rdy_pct, input int vld_pct,
                             input int abort_at);
        int acc = 0, nout = 0, ndone = 0, cyc = 0;
        bit held = 1'b0;
        int held_data = 0, held_last = 0;
        bit checking;
        checking = (abort_at == 0);
        mode_i   = mode[0];
        thresh_i = (PW+4)'(thr);
        while ((acc < NPIX || (checking && exp_q.size() > 0)) && cyc < 4000) begin
            @(negedge clk);
            in_valid_i  = (acc < NPIX) && ($urandom_range(99) < vld_pct);
            in_data_i   = (acc < NPIX) ? PW'(img[acc / W][acc % W]) : '0;
            out_ready_i = ($urandom_range(99) < rdy_pct);
            #1;
            if (checking && held && out_valid_o) begin
                chk({tag, "_stall_data"}, int'(out_data_o), held_data);
                chk({tag, "_stall_last"}, int'(out_last_o), held_last);
            end
            if (frame_done_o) ndone++;
            if (checking && out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_extra_out"}, 1, 0);
                end else begin
                    chk({tag, "_data"}, int'(out_data_o), exp_q.pop_front());
                    chk({tag, "_last"}, int'(out_last_o), (nout == NOUT - 1) ? 1 : 0);
                end
                nout++;
            end
            held      = out_valid_o && !out_ready_i;
            held_data = int'(out_data_o);
            held_last = int'(out_last_o);
            if (in_valid_i && in_ready_o) begin
                acc++;
                if (acc == 10 && chg_thr >= 0) begin
                    thresh_i = (PW+4)'(chg_thr);
                    mode_i   = ~mode_i;
                end
                if (abort_at > 0 && acc == abort_at) break;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        if (!checking) return;
        chk({tag, "_timeout"}, (cyc >= 4000) ? 1 : 0, 0);
        chk({tag, "_count"}, nout, NOUT);
        chk({tag, "_done_pulses"}, ndone, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk({tag, "_idle_valid"}, int'(out_valid_o), 0);
            chk({tag, "_idle_busy"}, int'(busy_o), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        mode_i      = 1'b0;
        thresh_i    = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;

        vt[0].lo = 77; vt[0].hi = 77;  vt[0].mode = 0; vt[0].thr = 0;  vt[0].chg_thr = -1;  vt[0].rdy = 100;
        vt[0].exp = '{0, 0, 0, 0, 0, 0};
        vt[1].lo = 0;  vt[1].hi = 20;  vt[1].mode = 0; vt[1].thr = 0;  vt[1].chg_thr = -1;  vt[1].rdy = 100;
        vt[1].exp = '{0, 0, 80, 80, 0, 0};
        vt[2].lo = 0;  vt[2].hi = 20;  vt[2].mode = 1; vt[2].thr = 50; vt[2].chg_thr = 100; vt[2].rdy = 100;
        vt[2].exp = '{0, 0, 255, 255, 0, 0};
        vt[3].lo = 0;  vt[3].hi = 200; vt[3].mode = 0; vt[3].thr = 0;  vt[3].chg_thr = -1;  vt[3].rdy = 100;
        vt[3].exp = '{0, 0, 255, 255, 0, 0};
        vt[4].lo = 0;  vt[4].hi = 20;  vt[4].mode = 0; vt[4].thr = 0;  vt[4].chg_thr = -1;  vt[4].rdy = 30;
        vt[4].exp = '{0, 0, 80, 80, 0, 0};

        reset_dut();

        for (int v = 0; v < 5; v++) begin
            fill_step(vt[v].lo, vt[v].hi);
            exp_q.delete();
            for (int r = 0; r < H - 2; r++)
                for (int c = 0; c < W - 2; c++)
                    exp_q.push_back(vt[v].exp[c]);
            run_frame($sformatf("vec%0d", v), vt[v].mode, vt[v].thr, vt[v].chg_thr,
                      vt[v].rdy, 100, 0);
        end

        // Abandon a frame after 20 accepts, then a full frame must be clean.
        fill_step(0, 20);
        run_frame("abort", 0, 0, -1, 100, 100, 20);
        reset_dut();
        exp_q.delete();
        for (int r = 0; r < H - 2; r++)
            for (int c = 0; c < W - 2; c++)
                exp_q.push_back(vt[1].exp[c]);
        run_frame("post_abort", 0, 0, -1, 100, 100, 0);

        for (int f = 0; f < 4; f++) begin
            int m, t;
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    img[r][c] = int'($urandom_range(255));
            m = int'($urandom_range(1));
            t = int'($urandom_range(1200));
            fill_model(m, t);
            run_frame($sformatf("rand%0d", f), m, t, int'($urandom_range(1000)),
                      50, 70, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
